// File: rtl/btb_predictor.sv
// Branch target buffer: tagged entries with saturating direction counters.
// Fetch looks up combinationally on lookup_pc; writeback applies one
// resolved-branch update per cycle. Valid bits are cleared by a sequential
// sweep (INIT) after reset or on a flush request.
module btb_predictor #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 10,
    parameter int TAG_W = 5,
    parameter int CTR_W = 2,
    parameter int ALIGN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] lookup_pc,
    output logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    output logic            pred_hit,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush_req,
    output logic            ready
);

    localparam int DEPTH = 2 ** IDX_W;
    // Stored tag width; a single dummy bit when tag compare is disabled.
    localparam int TW = (TAG_W > 0) ? TAG_W : 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));
    localparam logic [PC_W-1:0]  STEP     = PC_W'(2 ** ALIGN);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic [DEPTH-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [DEPTH];
    logic [PC_W-1:0]   tgt_q  [DEPTH];
    logic [CTR_W-1:0]  ctr_q  [DEPTH];

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TW-1:0]     lk_tag, up_tag;
    logic              lk_tag_ok, up_tag_ok;
    logic              up_hit, up_go, wr_en;
    logic [CTR_W-1:0]  wr_ctr;
    logic [PC_W-1:0]   wr_tgt;
    logic              unused_pc_bits;

    assign lk_idx = lookup_pc[ALIGN+IDX_W-1:ALIGN];
    assign up_idx = upd_pc[ALIGN+IDX_W-1:ALIGN];

    generate
        if (TAG_W > 0) begin : g_tag
            assign lk_tag = lookup_pc[ALIGN+IDX_W+TAG_W-1:ALIGN+IDX_W];
            assign up_tag = upd_pc[ALIGN+IDX_W+TAG_W-1:ALIGN+IDX_W];
        end else begin : g_notag
            assign lk_tag = '0;
            assign up_tag = '0;
        end
    endgenerate

    // Alignment and upper PC bits take no part in indexing or tagging.
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    assign ready     = (state_q == RUN);
    assign lk_tag_ok = (TAG_W == 0) || (tag_q[lk_idx] == lk_tag);
    assign up_tag_ok = (TAG_W == 0) || (tag_q[up_idx] == up_tag);

    // Lookup: reads pre-update contents, no bypass from a same-cycle update.
    always_comb begin
        pred_hit   = ready & valid_q[lk_idx] & lk_tag_ok;
        pred_taken = pred_hit & ctr_q[lk_idx][CTR_W-1];
        pred_pc    = pred_taken ? tgt_q[lk_idx] : lookup_pc + STEP;
    end

    // Update decode: hit/miss against pre-edge contents, single write port.
    always_comb begin
        up_hit = valid_q[up_idx] & up_tag_ok;
        up_go  = ready & upd_valid & ~flush_req;
        wr_en  = up_go & (up_hit | upd_taken);
        wr_tgt = upd_taken ? upd_target : tgt_q[up_idx];
        wr_ctr = CTR_INIT;
        if (up_hit) begin
            if (upd_taken) begin
                wr_ctr = (ctr_q[up_idx] == CTR_MAX) ? ctr_q[up_idx] : ctr_q[up_idx] + 1'b1;
            end else begin
                wr_ctr = (ctr_q[up_idx] == '0) ? ctr_q[up_idx] : ctr_q[up_idx] - 1'b1;
            end
        end
    end

    // Next-state logic: sweep every index once in INIT, flush restarts it.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Valid bits: cleared one per cycle by the sweep, set on any write.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            valid_q[sweep_q] <= 1'b0;
        end else if (wr_en) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Entry payload storage; never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= wr_tgt;
            ctr_q[up_idx] <= wr_ctr;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// table-level behavioural model.
module tb_btb_predictor;

    localparam int PC_W  = 16;
    localparam int IDX_W = 4;
    localparam int TAG_W = 5;
    localparam int CTR_W = 2;
    localparam int ALIGN = 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CMAX  = (1 << CTR_W) - 1;
    localparam int CTHR  = 1 << (CTR_W - 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PC_W-1:0] lookup_pc = '0;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic            pred_hit;
    logic            upd_valid = 1'b0;
    logic [PC_W-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic [PC_W-1:0] upd_target = '0;
    logic            flush_req = 1'b0;
    logic            ready;

    int checks = 0;
    int errors = 0;

    // Behavioural model: whole-table view, sweep modelled as a countdown.
    bit m_valid [DEPTH];
    int m_tag   [DEPTH];
    int m_tgt   [DEPTH];
    int m_ctr   [DEPTH];
    int m_left = DEPTH;

    always #5 clk = ~clk;

    btb_predictor #(
        .PC_W (PC_W),
        .IDX_W(IDX_W),
        .TAG_W(TAG_W),
        .CTR_W(CTR_W),
        .ALIGN(ALIGN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_pc (lookup_pc),
        .pred_pc   (pred_pc),
        .pred_taken(pred_taken),
        .pred_hit  (pred_hit),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken),
        .upd_target(upd_target),
        .flush_req (flush_req),
        .ready     (ready)
    );

    function automatic int f_idx(int pc);
        return (pc >> ALIGN) % DEPTH;
    endfunction

    function automatic int f_tag(int pc);
        return (pc >> (ALIGN + IDX_W)) % (1 << TAG_W);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update(input int pc, input bit tk, input int tgt);
        int i;
        i = f_idx(pc);
        if (m_valid[i] && m_tag[i] == f_tag(pc)) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = f_tag(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = CTHR;
        end
    endtask

    // Model advance on each clock edge (or asynchronously on reset).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (flush_req) begin
            m_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else if (upd_valid) begin
            model_update(int'(upd_pc), upd_taken, int'(upd_target));
        end
    end

    // Compare DUT outputs with the model every cycle, away from the edge.
    always @(negedge clk) begin
        int  i;
        bit  e_ready, e_hit, e_tk;
        int  e_pc;
        i       = f_idx(int'(lookup_pc));
        e_ready = (m_left == 0);
        e_hit   = e_ready && m_valid[i] && (m_tag[i] == f_tag(int'(lookup_pc)));
        e_tk    = e_hit && (m_ctr[i] >= CTHR);
        e_pc    = e_tk ? m_tgt[i] : (int'(lookup_pc) + (1 << ALIGN)) % (1 << PC_W);
        check("cyc.ready", 32'(ready), 32'(e_ready));
        check("cyc.hit", 32'(pred_hit), 32'(e_hit));
        check("cyc.taken", 32'(pred_taken), 32'(e_tk));
        check("cyc.pred_pc", 32'(pred_pc), e_pc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tgt);
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_valid  = 1'b1;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic lk(input string name, input logic [PC_W-1:0] pc,
                      input logic hit, input logic tk, input logic [PC_W-1:0] ppc);
        lookup_pc = pc;
        #1;
        check({name, ".hit"}, 32'(pred_hit), 32'(hit));
        check({name, ".taken"}, 32'(pred_taken), 32'(tk));
        check({name, ".pred_pc"}, 32'(pred_pc), 32'(ppc));
    endtask

    // Counts edges until ready rises, bounded so a stuck sweep still ends.
    task automatic sweep_len(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, n, DEPTH);
    endtask

    function automatic logic [PC_W-1:0] rand_pc();
        if ($urandom % 8 == 0) return PC_W'($urandom);
        return PC_W'($urandom_range(0, 255));
    endfunction

    initial begin
        // Reset and sweep length.
        repeat (3) tick();
        check("rst.ready", 32'(ready), 0);
        check("rst.hit", 32'(pred_hit), 0);
        rst_n = 1'b1;
        sweep_len("rst.sweep_len");
        lk("miss10", 16'h0010, 1'b0, 1'b0, 16'h0012);

        // First allocation, weakly taken.
        upd(16'h0024, 1'b1, 16'h0100);
        lk("alloc24", 16'h0024, 1'b1, 1'b1, 16'h0100);

        // Saturation high, then down to zero, then floor check.
        repeat (5) upd(16'h0024, 1'b1, 16'h0100);
        repeat (3) upd(16'h0024, 1'b0, 16'h0000);
        lk("sat0", 16'h0024, 1'b1, 1'b0, 16'h0026);
        upd(16'h0024, 1'b0, 16'h0000);
        upd(16'h0024, 1'b1, 16'h0100);
        lk("floor1", 16'h0024, 1'b1, 1'b0, 16'h0026);
        upd(16'h0024, 1'b1, 16'h0100);
        lk("ctr2", 16'h0024, 1'b1, 1'b1, 16'h0100);
        upd(16'h0040, 1'b0, 16'h0300);
        lk("nt_miss40", 16'h0040, 1'b0, 1'b0, 16'h0042);

        // Tag alias at index 2.
        lk("alias64", 16'h0064, 1'b0, 1'b0, 16'h0066);
        upd(16'h0064, 1'b1, 16'h0200);
        lk("repl64", 16'h0064, 1'b1, 1'b1, 16'h0200);
        lk("evict24", 16'h0024, 1'b0, 1'b0, 16'h0026);
        upd(16'h0024, 1'b1, 16'h0100);
        lk("realloc24", 16'h0024, 1'b1, 1'b1, 16'h0100);

        // Same-cycle lookup and update: old contents first.
        lookup_pc  = 16'h004A;
        upd_pc     = 16'h004A;
        upd_taken  = 1'b1;
        upd_target = 16'h0ABC;
        upd_valid  = 1'b1;
        #1;
        check("nobypass.hit", 32'(pred_hit), 0);
        tick();
        upd_valid = 1'b0;
        lk("after4A", 16'h004A, 1'b1, 1'b1, 16'h0ABC);

        // Flush with a simultaneous update that must be dropped.
        flush_req  = 1'b1;
        upd_pc     = 16'h0030;
        upd_taken  = 1'b1;
        upd_target = 16'h0400;
        upd_valid  = 1'b1;
        tick();
        flush_req = 1'b0;
        upd_valid = 1'b0;
        check("flush.ready", 32'(ready), 0);
        sweep_len("flush.sweep_len");
        lk("fl24", 16'h0024, 1'b0, 1'b0, 16'h0026);
        lk("fl30", 16'h0030, 1'b0, 1'b0, 16'h0032);
        lk("fl4A", 16'h004A, 1'b0, 1'b0, 16'h004C);

        // Reset mid-sweep restarts the full sweep; PC wrap on miss.
        upd(16'h0024, 1'b1, 16'h0100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        check("mid.ready", 32'(ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid.rst_ready", 32'(ready), 0);
        tick();
        rst_n = 1'b1;
        sweep_len("mid.sweep_len");
        lk("mid24", 16'h0024, 1'b0, 1'b0, 16'h0026);
        lk("wrap", 16'hFFFE, 1'b0, 1'b0, 16'h0000);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 3000; n++) begin
            upd_valid  = ($urandom % 3) != 0;
            upd_pc     = rand_pc();
            upd_taken  = ($urandom % 3) != 0;
            upd_target = PC_W'($urandom);
            flush_req  = ($urandom % 250) == 0;
            lookup_pc  = ($urandom % 4 == 0) ? upd_pc : rand_pc();
            if (n == 1500) rst_n = 1'b0;
            if (n == 1503) rst_n = 1'b1;
            tick();
        end
        upd_valid = 1'b0;
        flush_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
